// File: rtl/fifo_wr_arbiter.sv
// Round-robin, burst-aware arbiter in front of the write port of the dual-clock FIFO.
// Each accepted word carries the winning requester's index in its upper bits.
module fifo_wr_arbiter #(
  parameter int NUM_REQ      = 4,
  parameter int DATA_WIDTH   = 8,
  parameter int MAX_BURST    = 8,
  parameter int IDLE_TIMEOUT = 4,
  parameter int ID_BITS      = $clog2(NUM_REQ)
) (
  input  logic                          wr_clk,
  input  logic                          wr_rst_n,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  input  logic [NUM_REQ-1:0]            req_last,
  output logic [NUM_REQ-1:0]            req_ready,
  input  logic                          fifo_full,
  output logic                          fifo_wr_en,
  output logic [ID_BITS+DATA_WIDTH-1:0] fifo_wr_data,
  output logic [ID_BITS-1:0]            grant_id,
  output logic                          busy
);

  typedef enum logic {ARB, GRANT} state_t;

  localparam logic [7:0]         BURST_LIM = 8'(MAX_BURST);
  localparam logic [7:0]         IDLE_LIM  = 8'(IDLE_TIMEOUT);
  localparam logic [ID_BITS-1:0] LAST_RST  = ID_BITS'(NUM_REQ - 1);

  state_t                state_q, state_d;
  logic [ID_BITS-1:0]    grant_q, grant_d;
  logic [ID_BITS-1:0]    last_q, last_d;
  logic [7:0]            burst_q, burst_d;
  logic [7:0]            idle_q, idle_d;
  logic [7:0]            burst_inc, idle_inc;
  logic                  g_valid, g_last, g_ready, xfer;
  logic [DATA_WIDTH-1:0] g_data;
  logic                  pick_found;
  logic [ID_BITS-1:0]    pick_id;

  // Scan from last+NUM_REQ down to last+1 so the nearest valid requester after last wins.
  function automatic logic [ID_BITS:0] rr_pick(input logic [NUM_REQ-1:0] v,
                                               input logic [ID_BITS-1:0] last);
    logic [ID_BITS:0]   res;
    logic [ID_BITS-1:0] idx;
    res = '0;
    for (int k = NUM_REQ; k >= 1; k--) begin
      idx = ID_BITS'((int'(last) + k) % NUM_REQ);
      if (v[idx]) res = {1'b1, idx};
    end
    return res;
  endfunction

  assign {pick_found, pick_id} = rr_pick(req_valid, last_q);

  assign g_valid   = req_valid[grant_q];
  assign g_last    = req_last[grant_q];
  assign g_data    = req_data[grant_q*DATA_WIDTH +: DATA_WIDTH];
  assign g_ready   = wr_rst_n && (state_q == GRANT) && !fifo_full;
  assign xfer      = g_ready && g_valid;
  assign burst_inc = burst_q + 8'd1;
  assign idle_inc  = idle_q + 8'd1;

  always_comb begin
    req_ready = '0;
    if (g_ready) req_ready = NUM_REQ'(1) << grant_q;
  end

  assign fifo_wr_en   = xfer;
  assign fifo_wr_data = {grant_q, g_data};
  assign grant_id     = grant_q;
  assign busy         = (state_q == GRANT);

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    last_d  = last_q;
    burst_d = burst_q;
    idle_d  = idle_q;
    case (state_q)
      ARB: begin
        if (pick_found) begin
          grant_d = pick_id;
          burst_d = '0;
          idle_d  = '0;
          state_d = GRANT;
        end
      end
      GRANT: begin
        // A stall on fifo_full (valid but not ready) holds both counters.
        if (xfer) begin
          burst_d = burst_inc;
          idle_d  = '0;
          if (g_last || (burst_inc == BURST_LIM)) begin
            state_d = ARB;
            last_d  = grant_q;
          end
        end else if (!g_valid) begin
          idle_d = idle_inc;
          if (idle_inc == IDLE_LIM) begin
            state_d = ARB;
            last_d  = grant_q;
          end
        end
      end
      default: state_d = ARB;
    endcase
  end

  always_ff @(posedge wr_clk) begin
    if (!wr_rst_n) begin
      state_q <= ARB;
      grant_q <= '0;
      last_q  <= LAST_RST;
      burst_q <= '0;
      idle_q  <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      last_q  <= last_d;
      burst_q <= burst_d;
      idle_q  <= idle_d;
    end
  end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed bench for fifo_wr_arbiter with default parameters (4 requesters, burst 8, timeout 4).
module tb_fifo_wr_arbiter;

  logic        wr_clk = 1'b0;
  logic        wr_rst_n;
  logic [3:0]  req_valid;
  logic [31:0] req_data;
  logic [3:0]  req_last;
  logic [3:0]  req_ready;
  logic        fifo_full;
  logic        fifo_wr_en;
  logic [9:0]  fifo_wr_data;
  logic [1:0]  grant_id;
  logic        busy;
  logic [7:0]  d [4];

  int vectors     = 0;
  int miscompares = 0;

  always #5 wr_clk = ~wr_clk;

  assign req_data = {d[3], d[2], d[1], d[0]};

  fifo_wr_arbiter #(
    .NUM_REQ(4), .DATA_WIDTH(8), .MAX_BURST(8), .IDLE_TIMEOUT(4)
  ) dut (
    .wr_clk(wr_clk), .wr_rst_n(wr_rst_n),
    .req_valid(req_valid), .req_data(req_data), .req_last(req_last),
    .req_ready(req_ready), .fifo_full(fifo_full), .fifo_wr_en(fifo_wr_en),
    .fifo_wr_data(fifo_wr_data), .grant_id(grant_id), .busy(busy)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge wr_clk);
    #1;
  endtask

  task automatic do_reset;
    req_valid = '0;
    req_last  = '0;
    fifo_full = 1'b0;
    wr_rst_n  = 1'b0;
    tick();
    wr_rst_n  = 1'b1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached, observed no finish expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int eg;
    logic een;
    int w;
    int words;

    for (int r = 0; r < 4; r++) d[r] = '0;
    req_valid = '0;
    req_last  = '0;
    fifo_full = 1'b0;
    wr_rst_n  = 1'b0;
    tick();
    tick();
    #1;
    check("rst_busy", busy, 0);
    check("rst_grant", grant_id, 0);
    check("rst_ready", req_ready, 0);
    check("rst_wren", fifo_wr_en, 0);
    wr_rst_n = 1'b1;

    // Single requester, three-word burst.
    req_valid = 4'b0001;
    d[0] = 8'hA0;
    #1;
    check("t1_arb_ready", req_ready, 0);
    check("t1_arb_busy", busy, 0);
    tick();
    #1;
    check("t1_busy", busy, 1);
    check("t1_grant", grant_id, 0);
    check("t1_ready", req_ready, 4'b0001);
    check("t1_w0_en", fifo_wr_en, 1);
    check("t1_w0_data", fifo_wr_data, 10'h0A0);
    tick();
    d[0] = 8'hA1;
    #1;
    check("t1_w1_en", fifo_wr_en, 1);
    check("t1_w1_data", fifo_wr_data, 10'h0A1);
    tick();
    d[0] = 8'hA2;
    req_last = 4'b0001;
    #1;
    check("t1_w2_en", fifo_wr_en, 1);
    check("t1_w2_data", fifo_wr_data, 10'h0A2);
    tick();
    req_valid = '0;
    req_last  = '0;
    #1;
    check("t1_rel_busy", busy, 0);
    check("t1_rel_grant", grant_id, 0);
    check("t1_rel_ready", req_ready, 0);
    check("t1_rel_en", fifo_wr_en, 0);

    // All four requesters streaming without last: 8 words each, one dead cycle between grants.
    do_reset();
    req_valid = 4'b1111;
    w = 0;
    words = 0;
    begin
      int cnt [4];
      for (int r = 0; r < 4; r++) cnt[r] = 0;
      for (int cyc = 0; cyc < 41; cyc++) begin
        eg  = (cyc / 9) % 4;
        een = (cyc % 9) != 0;
        for (int r = 0; r < 4; r++) d[r] = 8'(r * 16 + cnt[r]);
        #1;
        if (cyc < 36 && fifo_wr_en === 1'b1) words++;
        check("t2_en", fifo_wr_en, een);
        check("t2_busy", busy, een);
        if (een) begin
          check("t2_grant", grant_id, eg);
          check("t2_ready", req_ready, 32'(1 << eg));
          check("t2_data", fifo_wr_data, (eg << 8) | (eg * 16 + cnt[eg]));
          cnt[eg]++;
        end
        if (cyc == 35) check("t2_words_in_36", words, 32);
        tick();
      end
    end

    // fifo_full for 5 cycles in the middle of req2's burst.
    do_reset();
    req_valid = 4'b0100;
    w = 0;
    for (int cyc = 0; cyc < 15; cyc++) begin
      fifo_full = (cyc >= 3 && cyc <= 7);
      d[2] = 8'(32 + w);
      #1;
      if (cyc == 0) begin
        check("t3_arb_busy", busy, 0);
        check("t3_arb_en", fifo_wr_en, 0);
      end else if (cyc == 14) begin
        check("t3_rel_busy", busy, 0);
        check("t3_rel_grant", grant_id, 2);
      end else begin
        check("t3_busy", busy, 1);
        check("t3_grant", grant_id, 2);
        if (fifo_full) begin
          check("t3_full_en", fifo_wr_en, 0);
          check("t3_full_ready", req_ready, 0);
        end else begin
          check("t3_en", fifo_wr_en, 1);
          check("t3_data", fifo_wr_data, (2 << 8) | (32 + w));
          w++;
        end
      end
      tick();
    end
    fifo_full = 1'b0;

    // Idle timeout on req1 with req3 pending.
    do_reset();
    req_valid = 4'b0010;
    d[1] = 8'h10;
    #1;
    check("t4_arb_busy", busy, 0);
    tick();
    #1;
    check("t4_grant", grant_id, 1);
    check("t4_en", fifo_wr_en, 1);
    check("t4_data", fifo_wr_data, 10'h110);
    tick();
    req_valid = 4'b1000;
    d[3] = 8'h30;
    for (int i = 0; i < 4; i++) begin
      #1;
      check("t4_idle_busy", busy, 1);
      check("t4_idle_grant", grant_id, 1);
      check("t4_idle_ready", req_ready, 4'b0010);
      check("t4_idle_en", fifo_wr_en, 0);
      tick();
    end
    #1;
    check("t4_rel_busy", busy, 0);
    check("t4_rel_grant", grant_id, 1);
    check("t4_rel_en", fifo_wr_en, 0);
    tick();
    #1;
    check("t4_next_busy", busy, 1);
    check("t4_next_grant", grant_id, 3);
    check("t4_next_ready", req_ready, 4'b1000);
    check("t4_next_data", fifo_wr_data, 10'h330);
    tick();

    // Reset pulse in the middle of req3's burst.
    d[3] = 8'h31;
    #1;
    check("t5_w1_data", fifo_wr_data, 10'h331);
    tick();
    d[3] = 8'h32;
    d[0] = 8'h05;
    req_valid = 4'b1001;
    wr_rst_n = 1'b0;
    #1;
    check("t5_rstlow_ready", req_ready, 0);
    check("t5_rstlow_en", fifo_wr_en, 0);
    check("t5_rstlow_busy", busy, 1);
    tick();
    #1;
    check("t5_rstedge_busy", busy, 0);
    check("t5_rstedge_grant", grant_id, 0);
    check("t5_rstedge_ready", req_ready, 0);
    check("t5_rstedge_en", fifo_wr_en, 0);
    wr_rst_n = 1'b1;
    tick();
    req_last = 4'b0001;
    #1;
    check("t5_req0_grant", grant_id, 0);
    check("t5_req0_busy", busy, 1);
    check("t5_req0_ready", req_ready, 4'b0001);
    check("t5_req0_data", fifo_wr_data, 10'h005);
    tick();
    req_last = '0;
    #1;
    check("t5_rel_busy", busy, 0);
    tick();
    #1;
    check("t5_req3_grant", grant_id, 3);
    check("t5_req3_ready", req_ready, 4'b1000);
    check("t5_req3_data", fifo_wr_data, 10'h332);

    // Last coinciding with the burst limit on req0's eighth word.
    do_reset();
    req_valid = 4'b0011;
    d[1] = 8'h60;
    w = 0;
    for (int cyc = 0; cyc < 11; cyc++) begin
      d[0] = 8'(8'h50 + w);
      req_last = (cyc == 8) ? 4'b0001 : 4'b0000;
      #1;
      if (cyc == 0) begin
        check("t6_arb_busy", busy, 0);
      end else if (cyc <= 8) begin
        check("t6_grant", grant_id, 0);
        check("t6_en", fifo_wr_en, 1);
        check("t6_data", fifo_wr_data, 8'h50 + w);
        w++;
      end else if (cyc == 9) begin
        check("t6_rel_busy", busy, 0);
        check("t6_rel_en", fifo_wr_en, 0);
      end else begin
        check("t6_next_busy", busy, 1);
        check("t6_next_grant", grant_id, 1);
        check("t6_next_ready", req_ready, 4'b0010);
        check("t6_next_data", fifo_wr_data, 10'h160);
      end
      tick();
    end
    req_valid = '0;
    req_last  = '0;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
